// File: rtl/enc_3.sv
// ---------------------------------------------------------------------------
// enc_3 : encoder layer 3, six-lane fixed-point multiply-add with saturation.
//
//   y[i] = sat(w[i] * x + b[i]),  i = 0..5, signed Q(BITSIZE-12).12
//
// Free-running two-stage pipeline with no handshake. Every rising edge samples
// the inputs, and each input set reaches y two rising edges later.
//   stage 1 : full-width signed product, arithmetic shift right by FRAC_BITS
//             (floor), with the bias captured alongside it
//   stage 2 : full-width add of product and sign-extended bias, then
//             saturation to BITSIZE signed, registered into y
//
// Optional build macro:
//   ENC3_RELU_EN : clamps negative saturated results to zero in stage 2.
//                  Latency is the same with or without it.
//
// Ports:
//   clk    in   1           rising-edge clock
//   reset  in   1           asynchronous active-low reset, clears all state
//   w      in   BITSIZE*6   weights, lane i = w[BITSIZE*i +: BITSIZE]
//   x      in   BITSIZE     scalar activation shared by every lane
//   b      in   BITSIZE*6   biases, lane i = b[BITSIZE*i +: BITSIZE]
//   y      out  BITSIZE*6   results, lane i = y[BITSIZE*i +: BITSIZE]
// ---------------------------------------------------------------------------
module enc_3 #(
  parameter int BITSIZE   = 16,
  parameter int FRAC_BITS = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BITSIZE*6-1:0]   w,
  input  logic [BITSIZE-1:0]     x,
  input  logic [BITSIZE*6-1:0]   b,
  output logic [BITSIZE*6-1:0]   y
);

  localparam int LANES = 6;
  localparam int PW    = 2 * BITSIZE;

  // Saturation limits held at full product width so the compare is exact.
  localparam logic signed [PW-1:0] SAT_MAX =
    {{(PW-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

  // The activation is shared, so its sign extension is done once for all lanes.
  logic signed [PW-1:0] x_ext;
  assign x_ext = $signed({{BITSIZE{x[BITSIZE-1]}}, x});

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [BITSIZE-1:0] w_l;
    logic signed [PW-1:0]      w_ext;
    logic signed [PW-1:0]      prod_full;
    logic signed [PW-1:0]      prod_d, prod_q;
    logic signed [BITSIZE-1:0] bias_d, bias_q;
    logic signed [PW-1:0]      sum;
    logic signed [BITSIZE-1:0] sat;
    logic signed [BITSIZE-1:0] y_d, y_q;

    assign w_l    = $signed(w[BITSIZE*i +: BITSIZE]);
    assign bias_d = $signed(b[BITSIZE*i +: BITSIZE]);
    assign w_ext  = $signed({{BITSIZE{w_l[BITSIZE-1]}}, w_l});

    // A BITSIZE x BITSIZE signed product always fits in PW bits, so the
    // low PW bits of the PW x PW multiply are the exact product.
    assign prod_full = w_ext * x_ext;
    // Arithmetic shift: rounds toward negative infinity.
    assign prod_d    = prod_full >>> FRAC_BITS;

    // Stage 1: scaled product and its bias travel together.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        prod_q <= '0;
        bias_q <= '0;
      end else begin
        prod_q <= prod_d;
        bias_q <= bias_d;
      end
    end

    // Stage 2 combinational: the add is done at PW bits, where it cannot
    // overflow, so saturation only happens once at the very end.
    always_comb begin
      sum = prod_q + $signed({{(PW-BITSIZE){bias_q[BITSIZE-1]}}, bias_q});
      sat = sum[BITSIZE-1:0];
      if (sum > SAT_MAX) begin
        sat = SAT_MAX[BITSIZE-1:0];
      end else if (sum < SAT_MIN) begin
        sat = SAT_MIN[BITSIZE-1:0];
      end
`ifdef ENC3_RELU_EN
      y_d = sat[BITSIZE-1] ? '0 : sat;
`else
      y_d = sat;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        y_q <= '0;
      end else begin
        y_q <= y_d;
      end
    end

    assign y[BITSIZE*i +: BITSIZE] = y_q;
  end : g_lane

endmodule : enc_3

// File: tb/tb_enc_3.sv
// ---------------------------------------------------------------------------
// tb_enc_3 : directed, table-driven bench for enc_3 (default 16-bit Q4.12).
// Expected results are hand-computed constants; when ENC3_RELU_EN is defined
// the bench clamps negative expected lanes to zero.
// ---------------------------------------------------------------------------
module tb_enc_3;

  localparam int BW = 16;
  localparam int VW = BW * 6;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic [VW-1:0] w;
  logic [BW-1:0] x;
  logic [VW-1:0] b;
  logic [VW-1:0] y;

  always #5 clk = ~clk;

  enc_3 #(.BITSIZE(BW), .FRAC_BITS(12)) dut (
    .clk   (clk),
    .reset (reset),
    .w     (w),
    .x     (x),
    .b     (b),
    .y     (y)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [VW-1:0] act,
                       input logic [VW-1:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Lane 0 in the lowest slice.
  function automatic logic [VW-1:0] pack6(
    input logic [BW-1:0] a0, input logic [BW-1:0] a1, input logic [BW-1:0] a2,
    input logic [BW-1:0] a3, input logic [BW-1:0] a4, input logic [BW-1:0] a5);
    return {a5, a4, a3, a2, a1, a0};
  endfunction

  // Expected-result packer: identical to pack6 unless ReLU is built in.
  function automatic logic [VW-1:0] ex6(
    input logic [BW-1:0] a0, input logic [BW-1:0] a1, input logic [BW-1:0] a2,
    input logic [BW-1:0] a3, input logic [BW-1:0] a4, input logic [BW-1:0] a5);
    logic [VW-1:0] v;
    v = {a5, a4, a3, a2, a1, a0};
`ifdef ENC3_RELU_EN
    for (int i = 0; i < 6; i++) begin
      if (v[BW*i + BW-1]) v[BW*i +: BW] = '0;
    end
`endif
    return v;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    string         name;
    logic [VW-1:0] w;
    logic [BW-1:0] x;
    logic [VW-1:0] b;
    logic [VW-1:0] e;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input string name, input logic [VW-1:0] vw,
                         input logic [BW-1:0] vx, input logic [VW-1:0] vb,
                         input logic [VW-1:0] ve);
    vec_t v;
    v.name = name; v.w = vw; v.x = vx; v.b = vb; v.e = ve;
    tbl.push_back(v);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [VW-1:0] vw, input logic [BW-1:0] vx,
                       input logic [VW-1:0] vb);
    @(negedge clk);
    w = vw;
    x = vx;
    b = vb;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  logic [VW-1:0] nom_w, nom_b, nom_e, prev_e;
  logic [BW-1:0] exp_q[$];

  initial begin
    nom_w = pack6(16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000);
    nom_b = pack6(16'h0400, 16'h0400, 16'h0400, 16'h0400, 16'h0400, 16'h0400);
    nom_e = ex6  (16'h0C00, 16'h0C00, 16'h0C00, 16'h0C00, 16'h0C00, 16'h0C00);

    add_vec("nominal", nom_w, 16'h0800, nom_b, nom_e);
    add_vec("negative_lane0",
      pack6(16'hF000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000),
      16'h0800, nom_b,
      ex6(16'hFC00, 16'h0C00, 16'h0C00, 16'h0C00, 16'h0C00, 16'h0C00));
    add_vec("sat_pos_7fff",
      pack6(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF),
      16'h7FFF, nom_b,
      ex6(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF));
    add_vec("sat_neg_8000",
      pack6(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000),
      16'h7FFF,
      pack6(16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00),
      ex6(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000));
    add_vec("min_times_min",
      pack6(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000),
      16'h8000,
      pack6(16'h0000, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 16'h0000),
      ex6(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF));
    add_vec("lane_mapping",
      pack6(16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h5000, 16'h6000),
      16'h1000, '0,
      ex6(16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h5000, 16'h6000));
    add_vec("x_zero_is_bias",
      pack6(16'h1234, 16'h8000, 16'h7FFF, 16'hABCD, 16'h0001, 16'hFFFF),
      16'h0000,
      pack6(16'h0123, 16'hF456, 16'h7FFF, 16'h8000, 16'h0000, 16'h1234),
      ex6(16'h0123, 16'hF456, 16'h7FFF, 16'h8000, 16'h0000, 16'h1234));
    add_vec("floor_shift",
      pack6(16'hFFFF, 16'h0001, 16'h1800, 16'hF800, 16'h1000, 16'h0000),
      16'h0001, '0,
      ex6(16'hFFFF, 16'h0000, 16'h0001, 16'hFFFF, 16'h0001, 16'h0000));
    add_vec("pos_edge_sat", nom_w, 16'h7000,
      pack6(16'h0FFF, 16'h1000, 16'h0000, 16'hF000, 16'h7FFF, 16'h8000),
      ex6(16'h7FFF, 16'h7FFF, 16'h7000, 16'h6000, 16'h7FFF, 16'hF000));
    add_vec("neg_edge_sat", nom_w, 16'h9000,
      pack6(16'hF000, 16'hEFFF, 16'h0000, 16'h1000, 16'h8000, 16'h7FFF),
      ex6(16'h8000, 16'h8000, 16'h9000, 16'hA000, 16'h8000, 16'h0FFF));

    // ---------------- reset from power-up ----------------
    reset = 1'b0;
    w = nom_w; x = 16'h0800; b = nom_b;
    #1;
    check("reset_async_initial", y, '0);
    repeat (3) edge_sample();
    check("reset_held_low", y, '0);
    @(negedge clk);
    reset = 1'b1;
    edge_sample();
    check("reset_release_edge1", y, '0);
    edge_sample();
    check("reset_release_edge2", y, nom_e);

    // ---------------- table ----------------
    prev_e = nom_e;
    foreach (tbl[k]) begin
      drive(tbl[k].w, tbl[k].x, tbl[k].b);
      edge_sample();
      check({tbl[k].name, "_edge1_old"}, y, prev_e);
      edge_sample();
      check({tbl[k].name, "_edge2"}, y, tbl[k].e);
      edge_sample();
      check({tbl[k].name, "_held"}, y, tbl[k].e);
      prev_e = tbl[k].e;
    end

    // ---------------- mid-stream asynchronous reset ----------------
    drive(nom_w, 16'h0800, nom_b);
    repeat (2) edge_sample();
    check("midrst_pre", y, nom_e);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_async_clear", y, '0);
    edge_sample();
    check("midrst_held", y, '0);
    @(negedge clk);
    reset = 1'b1;
    edge_sample();
    check("midrst_release_edge1", y, '0);
    edge_sample();
    check("midrst_release_edge2", y, nom_e);

    // ---------------- throughput: new x every cycle ----------------
    // With w = 1.0 and b = 0 every lane equals x, two edges later.
    exp_q.delete();
    for (int c = 0; c < 7; c++) begin
      logic [BW-1:0] xv;
      case (c)
        0:       xv = 16'h0400;
        1:       xv = 16'h0800;
        2:       xv = 16'h0C00;
        default: xv = 16'h0C00;
      endcase
      @(negedge clk);
      w = nom_w; x = xv; b = '0;
      exp_q.push_back(xv);
      edge_sample();
      if (exp_q.size() == 2) begin
        logic [BW-1:0] e;
        e = exp_q.pop_front();
        check($sformatf("stream_cycle%0d", c), y, ex6(e, e, e, e, e, e));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_enc_3

// File: doc/enc_3.md
Name: enc_3

Overview:
- Encoder layer 3 of the fixed-point neural encoder datapath.
- Computes a 6x1 matrix-vector product plus bias: y[i] = sat(w[i]*x + b[i]) for i = 0..5.
- Six parallel signed Q4.12 lanes in a free-running two-stage pipeline.
- Sits between the previous encoder layer (scalar x) and the next layer (6-element y).

Parameters:
- BITSIZE, 16, word width of every element. Format is signed two's-complement Q(BITSIZE-12).12; 0x1000 = 1.0 at the default.
- FRAC_BITS, 12, number of fractional bits; the product is shifted right by this amount.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. The port is named reset as the codebase does; polarity and synchronicity are fixed.
- w  input  BITSIZE*6  weight column; lane i = w[BITSIZE*i +: BITSIZE].
- x  input  BITSIZE  scalar input activation, shared by all lanes.
- b  input  BITSIZE*6  bias vector; lane i = b[BITSIZE*i +: BITSIZE].
- y  output  BITSIZE*6  result vector; lane i = y[BITSIZE*i +: BITSIZE].

Behaviour:
- Reset (reset=0): all pipeline registers and y clear to 0 immediately, without waiting for a clock edge. The pipeline holds at 0 while reset is low.
- Pipeline is free-running, with no handshake. Inputs are sampled on every rising edge.
- Stage 1, per lane:
  - p[i] = signed(w[i]) * signed(x), full 2*BITSIZE-bit product.
  - Arithmetic shift right by FRAC_BITS (truncation toward negative infinity).
  - Bias b[i] is captured alongside the product.
  - Registered.
- Stage 2, per lane:
  - s = shifted product + sign-extended b[i], computed at full width (no intermediate saturation).
  - Saturate s to BITSIZE signed: s > 0x7FFF gives 0x7FFF; s < -0x8000 gives 0x8000.
  - Registered into y.
- Latency: exactly 2 rising edges from an input change to the corresponding y. Throughput is one result vector per cycle.
- Lanes are fully independent. Saturation in one lane does not affect the others.
- Boundaries:
  - 0x8000 * 0x8000 (+64.0) saturates to 0x7FFF.
  - x = 0 gives y[i] = b[i].
- Reset mid-stream: in-flight data is discarded. After release, the first valid y appears 2 edges later; in between, y reads 0.
- No X propagation: y is always a defined value after reset.

Optional Feature:
- Macro ENC3_RELU_EN.
- When defined: a ReLU is applied after saturation in stage 2. Negative results become 0x0000; non-negative results pass unchanged. Latency is unchanged.
- When undefined: y is the linear saturated result, and negative values are output as-is.

Test Plan:
- Reset: hold reset=0 with arbitrary inputs -> y = 0 asynchronously. Release -> first non-zero y appears after exactly 2 rising edges.
- Nominal: all w lanes 0x1000, x=0x0800, all b lanes 0x0400 -> every y lane = 0x0C00 (1.0*0.5+0.25), 2 cycles after application, then held.
- Negative: w lane0=0xF000, x=0x0800, b=0x0400 -> y lane0 = 0xFC00 without ENC3_RELU_EN; 0x0000 with it. Other lanes unaffected.
- Saturation:
  - w=0x7FFF, x=0x7FFF, b=0x0400 -> 0x7FFF.
  - w=0x8000, x=0x7FFF, b=0xFC00 -> 0x8000 (0x0000 with ReLU).
  - w=0x8000, x=0x8000 -> 0x7FFF.
- Lane independence/mapping: distinct w per lane (0x1000, 0x2000, ..., 0x6000), x=0x1000, b=0 -> y lanes = 0x1000..0x6000 in matching bit slices.
- Throughput: change x every cycle (0x0400, 0x0800, 0x0C00) with w=0x1000, b=0 -> y follows the same sequence delayed by 2 cycles, with no bubbles.
